// File: rtl/sfir_tap_delay_pkg.sv
// sfir_pkg: shared types and helpers for the sfir_tap_delay delay line.
//   sfir_state_e : fill/run control state
//   dmax_of()    : maximum delay (2*NBTAP) for a given tap count
//   clamp_depth(): maps a requested depth onto the legal range 1..dmax
package sfir_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } sfir_state_e;

  localparam int unsigned NBTAP_DEF = 4;
  localparam int unsigned DMAX_DEF  = 2 * NBTAP_DEF;

  function automatic int unsigned dmax_of(input int unsigned nbtap);
    return 2 * nbtap;
  endfunction

  function automatic int unsigned clamp_depth(input int unsigned depth_sel,
                                              input int unsigned dmax);
    if (depth_sel == 0)   return 1;
    if (depth_sel > dmax) return dmax;
    return depth_sel;
  endfunction

endpackage

// File: rtl/sfir_tap_delay_if.sv
// sfir_tap_delay_if: sample/control bundle for sfir_tap_delay.
//   slave  : the delay line (consumes en/in_valid/datain/flush/depth_sel)
//   master : the driver (front-end / bench)
// With SFIR_TAP_DELAY_TAPS_EN defined, taps_out/taps_vld are added for a
// parallel-tap FIR (stage i lane k at [(i*NCHAN+k)*DSIZE +: DSIZE]).
interface sfir_tap_delay_if #(
  parameter int DSIZE = 16,
  parameter int NBTAP = 4,
  parameter int NCHAN = 2
);
  localparam int DMAX = 2 * NBTAP;
  localparam int DW   = $clog2(DMAX + 1);

  logic                   en;
  logic                   in_valid;
  logic [NCHAN*DSIZE-1:0] datain;
  logic                   flush;
  logic [DW-1:0]          depth_sel;
  logic [NCHAN*DSIZE-1:0] dataout;
  logic                   out_valid;
  logic [DW-1:0]          fill_cnt;
  logic [DW-1:0]          depth_q;
`ifdef SFIR_TAP_DELAY_TAPS_EN
  logic [DMAX*NCHAN*DSIZE-1:0] taps_out;
  logic [DMAX-1:0]             taps_vld;

  modport slave (
    input  en, in_valid, datain, flush, depth_sel,
    output dataout, out_valid, fill_cnt, depth_q, taps_out, taps_vld
  );
  modport master (
    output en, in_valid, datain, flush, depth_sel,
    input  dataout, out_valid, fill_cnt, depth_q, taps_out, taps_vld
  );
`else
  modport slave (
    input  en, in_valid, datain, flush, depth_sel,
    output dataout, out_valid, fill_cnt, depth_q
  );
  modport master (
    output en, in_valid, datain, flush, depth_sel,
    input  dataout, out_valid, fill_cnt, depth_q
  );
`endif
endinterface

// File: rtl/sfir_tap_delay_lane_srl.sv
// sfir_lane_srl: one lane's data array plus its depth-select output mux.
//   clk     : clock
//   shift_i : advance the line by one sample
//   din_i   : incoming sample
//   sel_i   : active depth (1..DMAX); output taps stage[sel_i-1]
//   vld_i   : output qualifier; dout_o is forced to zero when low
//   dout_o  : delayed sample
//   taps_o  : raw stage contents (only with SFIR_TAP_DELAY_TAPS_EN)
// The array has no reset so it maps onto shift-register primitives.
module sfir_lane_srl #(
  parameter int DSIZE = 16,
  parameter int DMAX  = 8,
  parameter int DW    = 4
) (
  input  logic                       clk,
  input  logic                       shift_i,
  input  logic [DSIZE-1:0]           din_i,
  input  logic [DW-1:0]              sel_i,
  input  logic                       vld_i,
`ifdef SFIR_TAP_DELAY_TAPS_EN
  output logic [DMAX-1:0][DSIZE-1:0] taps_o,
`endif
  output logic [DSIZE-1:0]           dout_o
);

  (* srl_style = "srl_register" *)
  logic [DMAX-1:0][DSIZE-1:0] stage_q;

  always_ff @(posedge clk) begin
    if (shift_i) begin
      stage_q[0] <= din_i;
      for (int i = 1; i < DMAX; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  always_comb begin
    dout_o = '0;
    if (vld_i) begin
      for (int i = 0; i < DMAX; i++)
        if (sel_i == DW'(i + 1)) dout_o = stage_q[i];
    end
  end

`ifdef SFIR_TAP_DELAY_TAPS_EN
  assign taps_o = stage_q;
`endif

endmodule

// File: rtl/sfir_tap_delay.sv
// sfir_tap_delay: NCHAN-lane runtime-programmable delay line (1..2*NBTAP).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sfir_tap_delay_if.slave (en, in_valid, datain, flush,
//                depth_sel in; dataout, out_valid, fill_cnt, depth_q out)
// Shared control (stage valids, FILL/RUN FSM, fill counter, depth register)
// lives here; each lane is an sfir_lane_srl.
// Optional: SFIR_TAP_DELAY_TAPS_EN exposes every stage on taps_out/taps_vld.
module sfir_tap_delay
  import sfir_pkg::*;
#(
  parameter int DSIZE = 16,
  parameter int NBTAP = 4,
  parameter int NCHAN = 2
) (
  input logic            clk,
  input logic            rst_n,
  sfir_tap_delay_if.slave bus
);

  localparam int unsigned DMAX = dmax_of(NBTAP);
  localparam int          DW   = $clog2(DMAX + 1);

  logic [DW-1:0]   depth_q, depth_d, fill_q, fill_d;
  logic [DMAX-1:0] vld_q, vld_d;
  sfir_state_e     state_q, state_d;
  logic            clr, shift, depth_chg, vld_sel, out_vld;

  // flush wins over a simultaneous sample; the sample is dropped
  assign clr       = bus.en && bus.flush;
  assign shift     = bus.en && bus.in_valid && !bus.flush;
  assign depth_d   = bus.en ? DW'(clamp_depth(32'(bus.depth_sel), DMAX)) : depth_q;
  assign depth_chg = bus.en && (depth_d != depth_q);

  always_comb begin
    vld_d = vld_q;
    fill_d = fill_q;
    if (clr) begin
      vld_d  = '0;
      fill_d = '0;
    end else begin
      if (shift) vld_d = {vld_q[DMAX-2:0], 1'b1};
      if (depth_chg)
        fill_d = shift ? DW'(1) : '0;
      else if (shift && fill_q != DW'(DMAX))
        fill_d = fill_q + DW'(1);
    end
  end

  // Readiness is judged on the values being registered this edge, so RUN
  // begins on the same edge the first sample lands in stage[depth-1].
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: if (bus.en && !clr && fill_d >= depth_d) state_d = RUN;
      RUN:  if (clr || depth_chg)
              state_d = (!clr && fill_d >= depth_d) ? RUN : FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      fill_q  <= '0;
      depth_q <= DW'(1);
      state_q <= FILL;
    end else if (bus.en) begin
      vld_q   <= vld_d;
      fill_q  <= fill_d;
      depth_q <= depth_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    vld_sel = 1'b0;
    for (int i = 0; i < DMAX; i++)
      if (depth_q == DW'(i + 1)) vld_sel = vld_q[i];
  end

  assign out_vld       = vld_sel && (state_q == RUN);
  assign bus.out_valid = out_vld;
  assign bus.fill_cnt  = fill_q;
  assign bus.depth_q   = depth_q;

`ifdef SFIR_TAP_DELAY_TAPS_EN
  logic [NCHAN-1:0][DMAX-1:0][DSIZE-1:0] taps;
  assign bus.taps_vld = vld_q;
  for (genvar s = 0; s < DMAX; s++) begin : g_tap_s
    for (genvar c = 0; c < NCHAN; c++) begin : g_tap_c
      assign bus.taps_out[(s*NCHAN+c)*DSIZE +: DSIZE] = taps[c][s];
    end
  end
`endif

  for (genvar k = 0; k < NCHAN; k++) begin : g_lane
    sfir_lane_srl #(.DSIZE(DSIZE), .DMAX(DMAX), .DW(DW)) u_lane (
      .clk    (clk),
      .shift_i(shift),
      .din_i  (bus.datain[k*DSIZE +: DSIZE]),
      .sel_i  (depth_q),
      .vld_i  (out_vld),
`ifdef SFIR_TAP_DELAY_TAPS_EN
      .taps_o (taps[k]),
`endif
      .dout_o (bus.dataout[k*DSIZE +: DSIZE])
    );
  end

endmodule

// File: tb/tb_sfir_tap_delay.sv
// Bench for sfir_tap_delay (DSIZE=16, NBTAP=4, NCHAN=2): table of stimulus
// with hand-derived fill_cnt/depth_q, a sample queue predicting out_valid
// and dataout, and hand sequences for reset behaviour.
module tb_sfir_tap_delay;

  localparam int DSIZE = 16;
  localparam int NBTAP = 4;
  localparam int NCHAN = 2;
  localparam int DMAX  = 2 * NBTAP;
  localparam int DW    = $clog2(DMAX + 1);

  typedef struct {
    bit       en;
    bit       iv;
    bit       fl;
    int       ds;
    int       d0;
    int       exp_fill;
    int       exp_depth;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sfir_tap_delay_if #(.DSIZE(DSIZE), .NBTAP(NBTAP), .NCHAN(NCHAN)) bus ();

  sfir_tap_delay #(.DSIZE(DSIZE), .NBTAP(NBTAP), .NCHAN(NCHAN)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  // model state: samples accepted since the last reset/flush/depth change
  logic [31:0] sq[$];
  int          m_depth = 1;
  int          m_fill  = 0;
  vec_t        tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int clampd(input int d);
    if (d < 1) return 1;
    if (d > DMAX) return DMAX;
    return d;
  endfunction

  function automatic vec_t v(input bit en, input bit iv, input bit fl, input int ds,
                             input int d0, input int ef, input int ed);
    vec_t r;
    r.en = en; r.iv = iv; r.fl = fl; r.ds = ds; r.d0 = d0;
    r.exp_fill = ef; r.exp_depth = ed;
    return r;
  endfunction

  task automatic model_reset();
    sq.delete();
    m_depth = 1;
    m_fill  = 0;
  endtask

  // drive one cycle, advance the model, and score out_valid/dataout
  task automatic step(input bit en, input bit iv, input bit fl, input int ds, input int d0);
    logic [31:0] smp;
    logic [31:0] exp_d;
    bit          exp_v;
    int          nd;
    smp = {16'(32'h100 + d0), 16'(d0)};
    bus.en = en; bus.in_valid = iv; bus.flush = fl;
    bus.depth_sel = DW'(ds);
    bus.datain = smp;
    @(posedge clk);
    #1;
    if (en) begin
      nd = clampd(ds);
      if (fl) begin
        sq.delete();
        m_fill = 0;
      end else begin
        if (nd != m_depth) begin
          sq.delete();
          m_fill = 0;
        end
        if (iv) begin
          sq.push_back(smp);
          if (m_fill < DMAX) m_fill++;
          if (sq.size() > DMAX) void'(sq.pop_front());
        end
      end
      m_depth = nd;
    end
    exp_v = (sq.size() >= m_depth);
    exp_d = exp_v ? sq[sq.size() - m_depth] : 32'h0;
    chk($sformatf("out_valid d0=%0d", d0), 64'(bus.out_valid), 64'(exp_v));
    chk($sformatf("dataout d0=%0d", d0), 64'(bus.dataout), 64'(exp_d));
  endtask

  initial begin
    bus.en = 1'b0; bus.in_valid = 1'b0; bus.flush = 1'b0;
    bus.depth_sel = '0; bus.datain = '0;

    // depth 3 continuous streaming
    for (int k = 1; k <= 5; k++) tbl.push_back(v(1, 1, 0, 3, k, k, 3));
    // depth 2 with bubbles
    tbl.push_back(v(1, 1, 0, 2, 6, 1, 2));
    tbl.push_back(v(1, 0, 0, 2, 7, 1, 2));
    tbl.push_back(v(1, 1, 0, 2, 8, 2, 2));
    tbl.push_back(v(1, 0, 0, 2, 9, 2, 2));
    tbl.push_back(v(1, 1, 0, 2, 10, 3, 2));
    tbl.push_back(v(1, 1, 0, 2, 11, 4, 2));
    // depth 4 then shrink to 2 while running
    for (int k = 12; k <= 16; k++) tbl.push_back(v(1, 1, 0, 4, k, k - 11, 4));
    for (int k = 17; k <= 19; k++) tbl.push_back(v(1, 1, 0, 2, k, k - 16, 2));
    // clamp: 0 -> 1, 15 -> 8
    tbl.push_back(v(1, 0, 0, 0, 20, 0, 1));
    tbl.push_back(v(1, 1, 0, 0, 21, 1, 1));
    tbl.push_back(v(1, 0, 0, 15, 22, 0, 8));
    for (int k = 23; k <= 30; k++) tbl.push_back(v(1, 1, 0, 8, k, k - 22, 8));
    // flush with a shift drops the sample; flush with en=0 is ignored
    tbl.push_back(v(1, 1, 1, 8, 31, 0, 8));
    tbl.push_back(v(0, 1, 1, 3, 32, 0, 8));
    for (int k = 33; k <= 40; k++) tbl.push_back(v(1, 1, 0, 8, k, k - 32, 8));
    tbl.push_back(v(1, 1, 0, 8, 41, 8, 8));  // fill_cnt saturates

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst dataout",   64'(bus.dataout),   64'd0);
    chk("rst fill_cnt",  64'(bus.fill_cnt),  64'd0);
    chk("rst depth_q",   64'(bus.depth_q),   64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].iv, tbl[i].fl, tbl[i].ds, tbl[i].d0);
      chk($sformatf("fill_cnt d0=%0d", tbl[i].d0), 64'(bus.fill_cnt), 64'(tbl[i].exp_fill));
      chk($sformatf("depth_q d0=%0d", tbl[i].d0), 64'(bus.depth_q), 64'(tbl[i].exp_depth));
    end

    // asynchronous reset mid-stream at depth 8: outputs drop before any edge
    chk("pre-rst out_valid", 64'(bus.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("async rst dataout",   64'(bus.dataout),   64'd0);
    chk("async rst fill_cnt",  64'(bus.fill_cnt),  64'd0);
    chk("async rst depth_q",   64'(bus.depth_q),   64'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // refill at depth 8 needs 8 shifts
    for (int k = 50; k < 59; k++) begin
      step(1, 1, 0, 8, k);
      chk($sformatf("refill fill_cnt d0=%0d", k), 64'(bus.fill_cnt), 64'(m_fill));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
